urv_pipe_ctrl: RTL and testbench
================================

Name: urv_pipe_ctrl

Overview:
Parametrised pipeline-control unit for the uRV core family. It replaces hand-written stall and kill equations with a generic N-stage controller. The controller merges per-stage stall requests, tracks the branch/trap kill shadow, and runs a halt/drain state machine for debug entry, plus a stall-cycle performance counter. It sits in the CPU top level between the stage modules and drives every stage's stall and kill inputs.

Parameters:
g_num_stages, 4, number of pipeline stages N (index 0 = fetch, N-1 = writeback); legal range 3..8.
g_bra_stage, 2, stage B that resolves branches/traps; 1 <= B <= N-2.
g_self_stall_mask, 4'b0100, N bits; bit k set means stage k is also stalled by its own request.
g_perf_width, 32, width of the stall-cycle counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
stall_req_i  in  N  per-stage stall request
stage_valid_i  in  N  per-stage "holds a valid instruction"
branch_take_i  in  1  branch taken in stage B (single-cycle pulse)
flush_i  in  1  trap/irq redirect from stage B (single-cycle pulse)
halt_req_i  in  1  request debug halt (level)
resume_i  in  1  leave halt (pulse)
stall_o  out  N  per-stage stall
kill_o  out  N  per-stage kill
fetch_hold_o  out  1  block fetch from issuing new instructions
halted_o  out  1  pipeline halted and empty
stall_cycles_o  out  g_perf_width  count of cycles with stall_o[0]=1

Behaviour:
- Stall, combinational: stall_o[k] = OR(stall_req_i[j], j>k) | (g_self_stall_mask[k] & stall_req_i[k]). With the defaults, stall_o[N-1]=0 always.
- Kill shadow:
  - sh[0] = branch_take_i | flush_i, combinational.
  - sh[1..B] are registers: sh[i] <= sh[i-1] when !stall_o[B], else hold.
  - kill_o[k] = OR(sh[0..k]) for 1<=k<=B.
  - kill_o[0]=0. kill_o[k]=0 for k>B.
  - With B=2: stage 2 is killed for 3 advancing cycles and stage 1 for 2.
- New branch inside an active shadow: the shadow restarts (shift register, OR semantics). No counter overflow is possible.
- Simultaneous branch_take_i and flush_i: treated as a single event.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN -> DRAIN when halt_req_i=1.
  - DRAIN: fetch_hold_o=1. Go to HALTED when stage_valid_i==0 and no sh[] bit is set (pipe empty) for 1 full cycle.
  - HALTED: fetch_hold_o=1, halted_o=1. Go to RUN on resume_i. In the RUN cycle after exit, fetch_hold_o=0.
  - resume_i in RUN or DRAIN: ignored.
  - halt_req_i dropping during DRAIN: completes to HALTED anyway (no abort).
  - flush_i during DRAIN: honoured (kills apply); drain continues.
- Perf counter: increments when stall_o[0]=1 and state != HALTED. Wraps modulo 2^g_perf_width, no saturation.
- Reset (rst_i=1 at a clock edge): sh[]=0, state=RUN, counter=0. After reset: stall_o follows its inputs, kill_o=0 (absent new pulses), fetch_hold_o=0, halted_o=0, stall_cycles_o=0. Reset mid-DRAIN or mid-HALTED returns to RUN on the next edge.
- Latency:
  - stall_o and kill_o[k] via sh[0]: 0 cycles.
  - State outputs: registered, 1 cycle after the causing edge.

Decomposition:
- Shared package urv_defs: stage index constants (URV_STAGE_F=0, D=1, X=2, W=3) and FSM state encodings (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2).
- One natural sub-module: urv_kill_shadow, containing the B-deep stall-gated shift register and the kill OR-tree.
- Stall merge and FSM stay in the top.

Test Plan:
1. Defaults, stall_req_i=4'b0010 -> stall_o=4'b0001. stall_req_i=4'b0100 -> stall_o=4'b0111. stall_req_i=4'b1000 -> stall_o=4'b0111.
2. branch_take_i pulse at cycle 0, no stalls -> kill_o[2]=1 cycles 0-2; kill_o[1]=1 cycles 0-1; kill_o[0]=0 and kill_o[3]=0 throughout.
3. Branch at cycle 0, stall_req_i[2]=1 in cycles 1-3 -> kill_o[2] stays 1 through cycle 5; shadow frozen while stalled.
4. Second branch at cycle 1 -> kill_o[2] is 1 for cycles 0-3.
5. halt_req_i=1 with stage_valid_i=4'b1111 draining to 0 at cycle 4 -> fetch_hold_o=1 from cycle 1; halted_o=1 at cycle 6; resume_i at cycle 10 -> halted_o=0 and fetch_hold_o=0 at cycle 11.
6. Perf counter preset to 2^32-2, stall 3 cycles -> stall_cycles_o=1. rst_i asserted during HALTED -> halted_o=0 and stall_cycles_o=0 next cycle.

Source files
------------

// File: rtl/urv_defs.sv
// uRV shared definitions: stage indices and pipeline-control FSM states.
package urv_defs;

  localparam int URV_STAGE_F = 0;
  localparam int URV_STAGE_D = 1;
  localparam int URV_STAGE_X = 2;
  localparam int URV_STAGE_W = 3;

  typedef enum logic [1:0] {
    URV_ST_RUN    = 2'd0,
    URV_ST_DRAIN  = 2'd1,
    URV_ST_HALTED = 2'd2
  } urv_state_e;

endpackage

// File: rtl/urv_kill_shadow.sv
// uRV kill shadow: stall-gated shift of branch/trap events
// and the per-stage kill OR-tree up to the resolving stage.
module urv_kill_shadow #(
  parameter int g_num_stages = 4,
  parameter int g_bra_stage  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sh0_i,
  input  logic                    adv_i,
  output logic [g_num_stages-1:0] kill_o,
  output logic                    busy_o
);

  localparam int B = g_bra_stage;

  logic [B:0]   sh;
  logic [B-1:0] sh_q;
  logic [B-1:0] sh_d;

  assign sh     = {sh_q, sh0_i};
  assign busy_o = |sh;

  always_comb begin
    sh_d = sh_q;
    if (adv_i) sh_d = sh[B-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sh_q <= '0;
    else       sh_q <= sh_d;
  end

  // stage k is killed while any event sits at depth 0..k
  always_comb begin
    logic acc;
    acc    = sh[0];
    kill_o = '0;
    for (int k = 1; k <= B; k++) begin
      acc       = acc | sh[k];
      kill_o[k] = acc;
    end
  end

endmodule

// File: rtl/urv_pipe_ctrl.sv
// uRV pipeline control: stall merge, kill shadow, halt/drain FSM
// and stall-cycle performance counter.
module urv_pipe_ctrl
  import urv_defs::*;
#(
  parameter int                    g_num_stages      = 4,
  parameter int                    g_bra_stage       = 2,
  parameter logic [g_num_stages-1:0] g_self_stall_mask = 4'b0100,
  parameter int                    g_perf_width      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_num_stages-1:0] stall_req_i,
  input  logic [g_num_stages-1:0] stage_valid_i,
  input  logic                    branch_take_i,
  input  logic                    flush_i,
  input  logic                    halt_req_i,
  input  logic                    resume_i,
  output logic [g_num_stages-1:0] stall_o,
  output logic [g_num_stages-1:0] kill_o,
  output logic                    fetch_hold_o,
  output logic                    halted_o,
  output logic [g_perf_width-1:0] stall_cycles_o
);

  localparam int N = g_num_stages;

  urv_state_e            state_q, state_d;
  logic                  empty_q, empty_d;
  logic [g_perf_width-1:0] cnt_q, cnt_d;
  logic                  sh_busy;
  logic                  pipe_empty;

  // a stage stalls when any younger-side stage downstream requests
  always_comb begin
    logic above;
    above   = 1'b0;
    stall_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      stall_o[k] = above | (g_self_stall_mask[k] & stall_req_i[k]);
      above      = above | stall_req_i[k];
    end
  end

  urv_kill_shadow #(
    .g_num_stages (N),
    .g_bra_stage  (g_bra_stage)
  ) u_shadow (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sh0_i  (branch_take_i | flush_i),
    .adv_i  (!stall_o[g_bra_stage]),
    .kill_o (kill_o),
    .busy_o (sh_busy)
  );

  assign pipe_empty = (stage_valid_i == '0) && !sh_busy;

  always_comb begin
    state_d = state_q;
    empty_d = pipe_empty;
    cnt_d   = cnt_q;
    unique case (state_q)
      URV_ST_RUN:    if (halt_req_i) state_d = URV_ST_DRAIN;
      URV_ST_DRAIN:  if (pipe_empty && empty_q) state_d = URV_ST_HALTED;
      URV_ST_HALTED: if (resume_i) state_d = URV_ST_RUN;
      default:       state_d = URV_ST_RUN;
    endcase
    if (stall_o[URV_STAGE_F] && state_q != URV_ST_HALTED)
      cnt_d = cnt_q + g_perf_width'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= URV_ST_RUN;
      empty_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      empty_q <= empty_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch_hold_o   = state_q != URV_ST_RUN;
  assign halted_o       = state_q == URV_ST_HALTED;
  assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Scoreboard bench for urv_pipe_ctrl: event-age reference model,
// directed sequences then randomized traffic.
module tb_urv_pipe_ctrl;

  localparam int N = 4;
  localparam int B = 2;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] val;
  logic         br;
  logic         fl;
  logic         hr;
  logic         res;
  logic [N-1:0] stall;
  logic [N-1:0] kill;
  logic         fh;
  logic         hl;
  logic [W-1:0] cnt;

  urv_pipe_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_req_i    (req),
    .stage_valid_i  (val),
    .branch_take_i  (br),
    .flush_i        (fl),
    .halt_req_i     (hr),
    .resume_i       (res),
    .stall_o        (stall),
    .kill_o         (kill),
    .fetch_hold_o   (fh),
    .halted_o       (hl),
    .stall_cycles_o (cnt)
  );

  typedef struct {
    logic [N-1:0] stall;
    logic [N-1:0] kill;
    logic         fh;
    logic         hl;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;

  int           ages[$];
  int           mode     = 0;
  bit           prev_empty = 0;
  logic [W-1:0] mcnt     = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req_v, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] vl,
                      input logic b, input logic f, input logic h,
                      input logic r, input logic rs, input bit chk);
    exp_t         e;
    logic [N-1:0] mask;
    logic [N-1:0] st;
    logic         above;
    logic         sh0;
    bit           busy;
    bit           empty;
    int           nxt[$];
    @(posedge clk);
    #1;
    req = rq; val = vl; br = b; fl = f; hr = h; res = r; rst = rs;
    mask  = 4'b0100;
    above = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      st[k] = above | (mask[k] & rq[k]);
      above = above | rq[k];
    end
    sh0    = b | f;
    e.kill = '0;
    for (int k = 1; k <= B; k++) begin
      e.kill[k] = sh0;
      foreach (ages[i]) if (ages[i] <= k) e.kill[k] = 1'b1;
    end
    e.stall = st;
    e.fh    = (mode != 0);
    e.hl    = (mode == 2);
    e.cnt   = mcnt;
    if (chk) sb.push_back(e);
    if (rs) begin
      ages.delete();
      mode       = 0;
      prev_empty = 0;
      mcnt       = '0;
    end else begin
      busy  = sh0 || (ages.size() > 0);
      empty = (vl == '0) && !busy;
      if (st[0] && mode != 2) mcnt = mcnt + 1;
      case (mode)
        0: if (h) mode = 1;
        1: if (empty && prev_empty) mode = 2;
        default: if (r) mode = 0;
      endcase
      prev_empty = empty;
      if (!st[B]) begin
        foreach (ages[i]) if (ages[i] + 1 <= B) nxt.push_back(ages[i] + 1);
        if (sh0) nxt.push_back(1);
        ages = nxt;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("stall_o", W'(stall), W'(e.stall));
        cmp("kill_o", W'(kill), W'(e.kill));
        cmp("fetch_hold_o", W'(fh), W'(e.fh));
        cmp("halted_o", W'(hl), W'(e.hl));
        cmp("stall_cycles_o", cnt, e.cnt);
      end
    end
  end

  initial begin
    logic hr_lvl;
    req = '0; val = '0; br = 0; fl = 0; hr = 0; res = 0; rst = 1;
    step('0, '0, 0, 0, 0, 0, 1, 0);
    step('0, '0, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(4'b0010, '0, 0, 0, 0, 0, 0, 1);
    step(4'b0100, '0, 0, 0, 0, 0, 0, 1);
    step(4'b1000, '0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step('0, '0, 1, 0, 0, 0, 0, 1);
    idle(4);
    step('0, '0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(4'b0100, '0, 0, 0, 0, 0, 0, 1);
    idle(4);
    step('0, '0, 1, 0, 0, 0, 0, 1);
    step('0, '0, 1, 0, 0, 0, 0, 1);
    idle(5);
    step('0, '0, 1, 1, 0, 0, 0, 1);
    idle(4);
    for (int c = 0; c < 14; c++)
      step('0, (c < 4) ? 4'b1111 : 4'b0000, 0, 0, c < 5, c == 10, 0, 1);
    idle(2);
    for (int i = 0; i < 3; i++) step(4'b0010, 4'b0011, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 6; c++) step(4'b0001, '0, 0, 0, 1, 0, 0, 1);
    step(4'b0001, '0, 0, 0, 1, 0, 1, 1);
    step('0, '0, 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int c = 0; c < 6; c++) step('0, '0, 0, 0, 1, 0, 0, 1);
    step('0, '0, 1, 0, 0, 0, 0, 1);
    idle(3);
    step('0, '0, 0, 0, 0, 1, 0, 1);
    idle(2);
    hr_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] rq;
      for (int k = 0; k < N; k++) rq[k] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) hr_lvl = ~hr_lvl;
      step(rq,
           ($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0,
           hr_lvl,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 199) == 0,
           1);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard_drained", W'(sb.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
